// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Brief    : Shared types and constants for the mux_4by1_rr combiner.
//  Options  : MUX_FIXED_PRIO_EN (consumed by rr_arb4; selects fixed priority)
//  Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } mux_state_t;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // Expand a channel index into the matching one-hot ready vector
    function automatic logic [NUM_CH-1:0] sel_to_onehot(input ch_sel_t sel);
        logic [NUM_CH-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb4
//  Brief    : Combinational 4-way arbiter. Searches req starting at ptr and
//             wrapping mod 4; the first requester found is granted.
//  Options  : MUX_FIXED_PRIO_EN - search always starts at channel 0, so
//             channel 0 is highest priority and ptr is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb4
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_vld,
    output logic [SEL_W-1:0]  gnt_idx
);

    ch_sel_t start;
    ch_sel_t cand;

`ifdef MUX_FIXED_PRIO_EN
    // Priority is fixed; the pointer input is kept only for a uniform interface
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign start      = '0;
`else
    assign start      = ptr;
`endif

    // Walk offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = start + SEL_W'(i);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_4by1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mux_4by1_rr
//  Brief    : Sequential 4:1 combining mux. Four valid/ready input channels
//             are arbitrated onto one registered output beat tagged with its
//             source channel (out_sel), ready for a downstream 1:4 demux.
//  Options  : MUX_FIXED_PRIO_EN - fixed priority (ch0 highest), no rr_ptr.
//             Default build is round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_4by1_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    mux_state_t       state;
    mux_state_t       state_next;
    ch_sel_t          arb_ptr;
    logic             gnt_vld;
    ch_sel_t          gnt_idx;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] ch_data [NUM_CH];

    // Split the packed input bus into per-channel words
    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    rr_arb4 u_arb (
        .req     (in_valid),
        .ptr     (arb_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

`ifdef MUX_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    ch_sel_t rr_ptr;

    // Pointer moves just past the last winner, only when a beat is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= gnt_idx + SEL_W'(1);
        end
    end

    assign arb_ptr = rr_ptr;
`endif

    // The single output slot can accept a beat when empty or draining now
    assign can_load  = (state == EMPTY) || out_ready;
    assign out_valid = (state == FULL);
    assign xfer      = |(in_ready & in_valid);

    // Ready goes only to the winner and never depends on data or during reset
    always_comb begin
        in_ready = '0;
        if (!rst && gnt_vld && can_load) begin
            in_ready = sel_to_onehot(gnt_idx);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: load fills the slot, drain without refill empties it
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (xfer) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready && !xfer) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Output beat registers change only on a load; draining leaves them as is
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (xfer) begin
            out_data <= ch_data[gnt_idx];
            out_sel  <= gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_4by1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_4by1_rr
//  Brief    : Self-checking bench for mux_4by1_rr. A cycle table gives the
//             stimulus and the hand-derived ready grant; accepted beats go
//             into a scoreboard queue and are compared when drained.
//  Options  : MUX_FIXED_PRIO_EN - expected grant becomes lowest valid channel.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_4by1_rr;

    localparam int WIDTH = 8;
    localparam int NROWS = 28;

    logic              clk;
    logic              rst;
    logic [3:0]        in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]        in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [1:0]        out_sel;
    logic              out_ready;

    mux_4by1_rr #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        ordy;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } beat_t;

    vec_t  tbl [NROWS];
    beat_t sb [$];
    int    checks;
    int    failures;
    logic  model_full;
    logic  prev_rst;

    localparam logic [31:0] DA = 32'hA3A2A1A0;

    task automatic set_row(input int i, input logic r, input logic [3:0] v,
                           input logic o, input logic [31:0] d, input logic [3:0] e);
        tbl[i].rst     = r;
        tbl[i].valid   = v;
        tbl[i].ordy    = o;
        tbl[i].data    = d;
        tbl[i].exp_rdy = e;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_rdy;
        logic       xfer;
        beat_t      b;
        int         idx;

        checks     = 0;
        failures   = 0;
        model_full = 1'b0;
        prev_rst   = 1'b0;

        // reset with all channels requesting
        set_row( 0, 1, 4'b1111, 1, DA, 4'b0000);
        set_row( 1, 1, 4'b1111, 1, DA, 4'b0000);
        // full rotation 0,1,2,3,0
        set_row( 2, 0, 4'b1111, 1, DA, 4'b0001);
        set_row( 3, 0, 4'b1111, 1, DA, 4'b0010);
        set_row( 4, 0, 4'b1111, 1, DA, 4'b0100);
        set_row( 5, 0, 4'b1111, 1, DA, 4'b1000);
        set_row( 6, 0, 4'b1111, 1, DA, 4'b0001);
        // load ch2=5C, then backpressure three cycles, then release -> ch3
        set_row( 7, 0, 4'b0100, 1, 32'hA35CA1A0, 4'b0100);
        set_row( 8, 0, 4'b1111, 0, DA, 4'b0000);
        set_row( 9, 0, 4'b1111, 0, DA, 4'b0000);
        set_row(10, 0, 4'b1111, 0, DA, 4'b0000);
        set_row(11, 0, 4'b1111, 1, DA, 4'b1000);
        // bring rr_ptr to 2, then sparse ch1/ch3 -> 3,1,3,1
        set_row(12, 0, 4'b0010, 1, DA, 4'b0010);
        set_row(13, 0, 4'b1010, 1, DA, 4'b1000);
        set_row(14, 0, 4'b1010, 1, DA, 4'b0010);
        set_row(15, 0, 4'b1010, 1, DA, 4'b1000);
        set_row(16, 0, 4'b1010, 1, DA, 4'b0010);
        // single ch3=FF, drain to empty, idle, then ch0 granted at once
        set_row(17, 0, 4'b1000, 1, 32'hFFA2A1A0, 4'b1000);
        set_row(18, 0, 4'b0000, 1, DA, 4'b0000);
        set_row(19, 0, 4'b0000, 1, DA, 4'b0000);
        set_row(20, 0, 4'b0001, 1, DA, 4'b0001);
        set_row(21, 0, 4'b0000, 0, DA, 4'b0000);
        // mid-operation reset while FULL and stalled
        set_row(22, 1, 4'b1111, 0, DA, 4'b0000);
        set_row(23, 0, 4'b1111, 1, DA, 4'b0001);
        set_row(24, 0, 4'b1010, 1, DA, 4'b0010);
        set_row(25, 0, 4'b1010, 0, DA, 4'b0000);
        set_row(26, 0, 4'b0000, 1, DA, 4'b0000);
        set_row(27, 0, 4'b0000, 1, DA, 4'b0000);

        for (int i = 0; i < NROWS; i++) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].valid;
            out_ready = tbl[i].ordy;
            in_data   = tbl[i].data;

            @(negedge clk);

`ifdef MUX_FIXED_PRIO_EN
            exp_rdy = 4'b0000;
            if (!tbl[i].rst && (!model_full || tbl[i].ordy)) begin
                for (int c = 3; c >= 0; c--) begin
                    if (tbl[i].valid[c]) exp_rdy = 4'b0001 << c;
                end
            end
`else
            exp_rdy = tbl[i].exp_rdy;
`endif
            check($sformatf("in_ready row%0d", i), {28'd0, in_ready}, {28'd0, exp_rdy});
            check($sformatf("out_valid row%0d", i), {31'd0, out_valid}, {31'd0, model_full});

            if (prev_rst) begin
                check($sformatf("out_sel_after_rst row%0d", i), {30'd0, out_sel}, 32'd0);
            end

            // held beat must stay stable while stalled
            if (model_full && !tbl[i].ordy && !tbl[i].rst && sb.size() > 0) begin
                check($sformatf("hold row%0d", i), {22'd0, out_sel, out_data},
                      {22'd0, sb[0].sel, sb[0].data});
            end

            @(posedge clk);

            if (tbl[i].rst) begin
                sb.delete();
                model_full = 1'b0;
            end else begin
                xfer = |(exp_rdy & tbl[i].valid);
                if (model_full && tbl[i].ordy) begin
                    if (sb.size() == 0) begin
                        failures++;
                        checks++;
                        $display("FAIL sb_underflow row%0d: queue empty, one beat required", i);
                    end else begin
                        b = sb.pop_front();
                        check($sformatf("drain row%0d", i), {22'd0, out_sel, out_data},
                              {22'd0, b.sel, b.data});
                    end
                end
                if (xfer) begin
                    idx = 0;
                    for (int c = 0; c < 4; c++) begin
                        if (exp_rdy[c]) idx = c;
                    end
                    b.sel  = 2'(idx);
                    b.data = tbl[i].data[idx*8 +: 8];
                    sb.push_back(b);
                end
                model_full = xfer ? 1'b1 : (model_full && !tbl[i].ordy);
            end
            prev_rst = tbl[i].rst;
            #1;
        end

        check("sb_empty_at_end", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
